// File: rtl/gesture_window_scheduler_if.sv
// Control/status bundle between the gesture window scheduler and the
// event front end, accumulator, classifier and output persistence stage.
interface gesture_window_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             event_valid;
  logic             class_valid;
  logic             gesture_valid;
  logic             acc_clear;
  logic             acc_hold;
  logic             class_start;
  logic             cooldown_active;
  logic             timeout_err;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] window_count;
  logic [1:0]       sched_state;

  modport master (
    output enable, event_valid, class_valid, gesture_valid,
    input  acc_clear, acc_hold, class_start, cooldown_active, timeout_err,
           event_count, window_count, sched_state
  );

  modport slave (
    input  enable, event_valid, class_valid, gesture_valid,
    output acc_clear, acc_hold, class_start, cooldown_active, timeout_err,
           event_count, window_count, sched_state
  );
endinterface

// File: rtl/gesture_window_scheduler.sv
// Fixed-window scheduler for the gesture classifier: counts events per window,
// gates classification on activity, tracks timeouts and post-gesture cooldown.
module gesture_window_scheduler #(
  parameter int WINDOW_CYCLES    = 1000,
  parameter int MIN_EVENTS       = 8,
  parameter int CLASS_TIMEOUT    = 64,
  parameter int COOLDOWN_WINDOWS = 3,
  parameter int CNT_W            = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  gesture_window_scheduler_if.slave  bus
);
  localparam int CYC_W = $clog2(WINDOW_CYCLES);
  localparam int TMO_W = $clog2(CLASS_TIMEOUT);
  localparam int CD_W  = (COOLDOWN_WINDOWS > 0) ? $clog2(COOLDOWN_WINDOWS + 1) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CLASS_TIMEOUT - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_WINDOWS);
  localparam logic [CNT_W:0]   MIN_EXT  = (CNT_W + 1)'(MIN_EVENTS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    CLASSIFY = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CYC_W-1:0]  cyc_reg, cyc_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [CD_W-1:0]   cooldown_reg, cooldown_next;
  logic [CNT_W-1:0]  event_count_reg, event_count_next;
  logic [CNT_W-1:0]  window_count_reg, window_count_next;
  logic              acc_clear_reg, acc_clear_next;
  logic              class_start_reg, class_start_next;
  logic              acc_hold_reg, acc_hold_next;
  logic              timeout_err_reg, timeout_err_next;
  logic              cooldown_active_reg;

  // Unsaturated sum keeps the threshold compare exact even when the count pins.
  logic [CNT_W:0]    ev_sum;
  logic [CNT_W-1:0]  ev_sat;

  always_comb begin
    ev_sum = {1'b0, event_count_reg} + (CNT_W + 1)'(bus.event_valid);
    ev_sat = ev_sum[CNT_W] ? '1 : ev_sum[CNT_W-1:0];

    state_next        = state_reg;
    cyc_next          = cyc_reg;
    tmo_next          = tmo_reg;
    cooldown_next     = cooldown_reg;
    event_count_next  = event_count_reg;
    window_count_next = window_count_reg;
    acc_clear_next    = 1'b0;
    class_start_next  = 1'b0;
    acc_hold_next     = acc_hold_reg;
    timeout_err_next  = timeout_err_reg;

    if (state_reg == IDLE) begin
      if (bus.enable) begin
        state_next       = ACCUM;
        cyc_next         = '0;
        event_count_next = '0;
        acc_clear_next   = 1'b1;
      end
    end else if (!bus.enable) begin
      state_next       = IDLE;
      acc_clear_next   = 1'b1;
      acc_hold_next    = 1'b0;
      cooldown_next    = '0;
      cyc_next         = '0;
      tmo_next         = '0;
      event_count_next = '0;
    end else if (state_reg == ACCUM) begin
      if (cyc_reg == CYC_LAST) begin
        window_count_next = window_count_reg + CNT_W'(1);
        cyc_next          = '0;
        if (cooldown_reg != '0) begin
          cooldown_next    = cooldown_reg - CD_W'(1);
          acc_clear_next   = 1'b1;
          event_count_next = '0;
        end else if (ev_sum < MIN_EXT) begin
          acc_clear_next   = 1'b1;
          event_count_next = '0;
        end else begin
          // The window's count stays visible to the classifier while it runs.
          class_start_next = 1'b1;
          acc_hold_next    = 1'b1;
          tmo_next         = '0;
          event_count_next = ev_sat;
          state_next       = CLASSIFY;
        end
      end else begin
        cyc_next         = cyc_reg + CYC_W'(1);
        event_count_next = ev_sat;
      end
      if (bus.gesture_valid) begin
        cooldown_next = CD_LOAD;
      end
    end else begin
      if (bus.class_valid || tmo_reg == TMO_LAST) begin
        timeout_err_next = timeout_err_reg | ~bus.class_valid;
        acc_clear_next   = 1'b1;
        acc_hold_next    = 1'b0;
        event_count_next = '0;
        cyc_next         = '0;
        state_next       = ACCUM;
      end else begin
        tmo_next = tmo_reg + TMO_W'(1);
      end
      if (bus.gesture_valid) begin
        cooldown_next = CD_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      cyc_reg             <= '0;
      tmo_reg             <= '0;
      cooldown_reg        <= '0;
      event_count_reg     <= '0;
      window_count_reg    <= '0;
      acc_clear_reg       <= 1'b0;
      class_start_reg     <= 1'b0;
      acc_hold_reg        <= 1'b0;
      timeout_err_reg     <= 1'b0;
      cooldown_active_reg <= 1'b0;
    end else begin
      state_reg           <= state_next;
      cyc_reg             <= cyc_next;
      tmo_reg             <= tmo_next;
      cooldown_reg        <= cooldown_next;
      event_count_reg     <= event_count_next;
      window_count_reg    <= window_count_next;
      acc_clear_reg       <= acc_clear_next;
      class_start_reg     <= class_start_next;
      acc_hold_reg        <= acc_hold_next;
      timeout_err_reg     <= timeout_err_next;
      cooldown_active_reg <= (cooldown_next != '0);
    end
  end

  assign bus.acc_clear       = acc_clear_reg;
  assign bus.acc_hold        = acc_hold_reg;
  assign bus.class_start     = class_start_reg;
  assign bus.cooldown_active = cooldown_active_reg;
  assign bus.timeout_err     = timeout_err_reg;
  assign bus.event_count     = event_count_reg;
  assign bus.window_count    = window_count_reg;
  assign bus.sched_state     = state_reg;
endmodule

// File: tb/tb_gesture_window_scheduler.sv
// Bench for gesture_window_scheduler: window-outcome table, directed corner
// sequences and a randomized run, all against an absolute-time event model.
module tb_gesture_window_scheduler;
  localparam int WIN  = 16;
  localparam int MINE = 4;
  localparam int TMO  = 8;
  localparam int CD   = 2;
  localparam int WMASK = 16'hFFFF;
  localparam int MAXC  = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gesture_window_scheduler_if #(.CNT_W(16)) ifc();
  gesture_window_scheduler_if #(.CNT_W(3))  sat_if();

  assign sat_if.enable        = ifc.enable;
  assign sat_if.event_valid   = ifc.event_valid;
  assign sat_if.class_valid   = ifc.class_valid;
  assign sat_if.gesture_valid = ifc.gesture_valid;

  gesture_window_scheduler #(
    .WINDOW_CYCLES(WIN), .MIN_EVENTS(MINE), .CLASS_TIMEOUT(TMO),
    .COOLDOWN_WINDOWS(CD), .CNT_W(16)
  ) dut (.clk(clk), .rst(rst), .bus(ifc));

  gesture_window_scheduler #(
    .WINDOW_CYCLES(WIN), .MIN_EVENTS(MINE), .CLASS_TIMEOUT(TMO),
    .COOLDOWN_WINDOWS(CD), .CNT_W(3)
  ) dut_sat (.clk(clk), .rst(rst), .bus(sat_if));

  int errors = 0;
  int checks = 0;

  // Reference model: windows and classification deadlines in absolute cycles.
  int now = 0;
  int m_state = 0;
  int win_start = 0;
  int cls_start = 0;
  int m_cnt = 0;
  int m_wins = 0;
  int m_cool = 0;
  bit m_err = 0, m_clear = 0, m_start = 0, m_hold = 0;

  task automatic model_step(input bit en, input bit ev, input bit cv, input bit gv);
    int total;
    m_clear = 0;
    m_start = 0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_wins = 0; m_cool = 0;
      m_err = 0; m_hold = 0;
    end else if (m_state == 0) begin
      if (en) begin
        m_state = 1; win_start = now + 1; m_cnt = 0; m_clear = 1;
      end
    end else if (!en) begin
      m_state = 0; m_clear = 1; m_hold = 0; m_cool = 0; m_cnt = 0;
    end else if (m_state == 1) begin
      total = m_cnt + int'(ev);
      if (now - win_start == WIN - 1) begin
        m_wins = (m_wins + 1) & WMASK;
        if (m_cool > 0) begin
          m_clear = 1; m_cnt = 0; win_start = now + 1;
          m_cool = gv ? CD : m_cool - 1;
        end else if (total < MINE) begin
          m_clear = 1; m_cnt = 0; win_start = now + 1;
          if (gv) m_cool = CD;
        end else begin
          m_start = 1; m_hold = 1; m_state = 2; cls_start = now + 1;
          m_cnt = (total > MAXC) ? MAXC : total;
          if (gv) m_cool = CD;
        end
      end else begin
        m_cnt = (total > MAXC) ? MAXC : total;
        if (gv) m_cool = CD;
      end
    end else begin
      if (gv) m_cool = CD;
      if (cv || (now - cls_start == TMO - 1)) begin
        if (!cv) m_err = 1;
        m_clear = 1; m_hold = 0; m_cnt = 0; m_state = 1; win_start = now + 1;
      end
    end
  endtask

  task automatic check_model();
    checks++;
    if (int'(ifc.sched_state) != m_state || ifc.acc_clear != m_clear ||
        ifc.class_start != m_start || ifc.acc_hold != m_hold ||
        ifc.cooldown_active != (m_cool != 0) || ifc.timeout_err != m_err ||
        int'(ifc.event_count) != m_cnt || int'(ifc.window_count) != m_wins) begin
      errors++;
      $display("FAIL model t=%0t: got st=%0d clr=%0b start=%0b hold=%0b cool=%0b err=%0b cnt=%0d win=%0d want st=%0d clr=%0b start=%0b hold=%0b cool=%0b err=%0b cnt=%0d win=%0d",
               $time, ifc.sched_state, ifc.acc_clear, ifc.class_start, ifc.acc_hold,
               ifc.cooldown_active, ifc.timeout_err, ifc.event_count, ifc.window_count,
               m_state, m_clear, m_start, m_hold, (m_cool != 0), m_err, m_cnt, m_wins);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit e, input bit v, input bit c, input bit g);
    ifc.enable = e; ifc.event_valid = v; ifc.class_valid = c; ifc.gesture_valid = g;
    model_step(e, v, c, g);
    @(posedge clk);
    #1;
    now++;
    check_model();
  endtask

  // Starts on the cyc==0 cycle of a window; returns on the decision cycle.
  task automatic run_window(input int pre, input bit last, input bit gv_first, input bit gv_last);
    for (int i = 0; i < WIN; i++) begin
      step(1'b1, (i < WIN - 1) ? (i < pre) : last, 1'b0,
           (i == 0 && gv_first) || (i == WIN - 1 && gv_last));
    end
  endtask

  typedef struct {
    int pre;
    bit last;
    bit start;
    int cnt;
    int sat_cnt;
  } row_t;

  row_t rows[8];

  initial begin
    rows[0] = '{3,  1'b1, 1'b1, 4,  4};
    rows[1] = '{3,  1'b0, 1'b0, 0,  0};
    rows[2] = '{0,  1'b0, 1'b0, 0,  0};
    rows[3] = '{5,  1'b0, 1'b1, 5,  5};
    rows[4] = '{4,  1'b0, 1'b1, 4,  4};
    rows[5] = '{0,  1'b1, 1'b0, 0,  0};
    rows[6] = '{15, 1'b1, 1'b1, 16, 7};
    rows[7] = '{9,  1'b0, 1'b1, 9,  7};

    ifc.enable = 0; ifc.event_valid = 0; ifc.class_valid = 0; ifc.gesture_valid = 0;

    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset state", int'(ifc.sched_state), 0);
    chk("reset acc_clear", int'(ifc.acc_clear), 0);
    chk("reset event_count", int'(ifc.event_count), 0);
    chk("reset window_count", int'(ifc.window_count), 0);
    chk("reset timeout_err", int'(ifc.timeout_err), 0);
    rst = 1'b0;
    $display("reset applied");

    // Basic classification with 5 events.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("enable acc_clear", int'(ifc.acc_clear), 1);
    run_window(5, 1'b0, 1'b0, 1'b0);
    chk("s1 class_start", int'(ifc.class_start), 1);
    chk("s1 acc_hold", int'(ifc.acc_hold), 1);
    chk("s1 event_count", int'(ifc.event_count), 5);
    chk("s1 state", int'(ifc.sched_state), 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("s1 done acc_clear", int'(ifc.acc_clear), 1);
    chk("s1 done state", int'(ifc.sched_state), 1);
    chk("s1 done event_count", int'(ifc.event_count), 0);
    chk("s1 done window_count", int'(ifc.window_count), 1);
    chk("s1 done acc_hold", int'(ifc.acc_hold), 0);
    $display("scenario basic classify done");

    // Window outcome table (threshold, end-cycle event, saturation).
    for (int r = 0; r < 8; r++) begin
      run_window(rows[r].pre, rows[r].last, 1'b0, 1'b0);
      $display("row %0d: pre=%0d last=%0b class_start=%0b event_count=%0d sat_count=%0d",
               r, rows[r].pre, rows[r].last, ifc.class_start, ifc.event_count, sat_if.event_count);
      chk($sformatf("row%0d class_start", r), int'(ifc.class_start), int'(rows[r].start));
      chk($sformatf("row%0d acc_clear", r), int'(ifc.acc_clear), int'(!rows[r].start));
      chk($sformatf("row%0d event_count", r), int'(ifc.event_count), rows[r].cnt);
      chk($sformatf("row%0d sat event_count", r), int'(sat_if.event_count), rows[r].sat_cnt);
      chk($sformatf("row%0d window_count", r), int'(ifc.window_count), 2 + r);
      if (rows[r].start) step(1'b1, 1'b0, 1'b1, 1'b0);
    end

    // class_valid exactly at the last timeout cycle wins.
    run_window(5, 1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tmo7 still classify", int'(ifc.sched_state), 2);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("tmo7 cv acc_clear", int'(ifc.acc_clear), 1);
    chk("tmo7 cv timeout_err", int'(ifc.timeout_err), 0);
    // Real timeout.
    run_window(5, 1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("timeout pending err", int'(ifc.timeout_err), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("timeout acc_clear", int'(ifc.acc_clear), 1);
    chk("timeout err", int'(ifc.timeout_err), 1);
    chk("timeout state", int'(ifc.sched_state), 1);
    chk("timeout acc_hold", int'(ifc.acc_hold), 0);
    $display("scenario timeout done");

    // Cooldown after a gesture: two suppressed windows, then classify.
    run_window(5, 1'b0, 1'b1, 1'b0);
    chk("cd w1 class_start", int'(ifc.class_start), 0);
    chk("cd w1 cooldown_active", int'(ifc.cooldown_active), 1);
    run_window(5, 1'b0, 1'b0, 1'b0);
    chk("cd w2 acc_clear", int'(ifc.acc_clear), 1);
    chk("cd w2 cooldown_active", int'(ifc.cooldown_active), 0);
    run_window(5, 1'b0, 1'b0, 1'b0);
    chk("cd w3 class_start", int'(ifc.class_start), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    // Gesture on a window-end cycle reloads instead of decrementing.
    run_window(5, 1'b0, 1'b1, 1'b0);
    run_window(5, 1'b0, 1'b0, 1'b1);
    chk("cd reload active", int'(ifc.cooldown_active), 1);
    run_window(5, 1'b0, 1'b0, 1'b0);
    chk("cd reload still active", int'(ifc.cooldown_active), 1);
    chk("cd reload no start", int'(ifc.class_start), 0);
    run_window(5, 1'b0, 1'b0, 1'b0);
    chk("cd reload drained", int'(ifc.cooldown_active), 0);
    run_window(5, 1'b0, 1'b0, 1'b0);
    chk("cd reload class_start", int'(ifc.class_start), 1);
    $display("scenario cooldown done");

    // Disable mid-classify, late class_valid, gesture in IDLE.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("disable state", int'(ifc.sched_state), 0);
    chk("disable acc_clear", int'(ifc.acc_clear), 1);
    chk("disable acc_hold", int'(ifc.acc_hold), 0);
    chk("disable event_count", int'(ifc.event_count), 0);
    chk("disable keeps err", int'(ifc.timeout_err), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("late cv state", int'(ifc.sched_state), 0);
    chk("late cv acc_clear", int'(ifc.acc_clear), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle gesture ignored", int'(ifc.cooldown_active), 0);
    $display("scenario disable done");

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      step($urandom_range(0, 99) < 97, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
    end
    rst = 1'b0;
    $display("random run done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
